// File: rtl/lsu_misalign_ctrl.sv
// lsu_misalign_ctrl: request-side load/store stage in front of the data TCM.
// Turns byte/half/word accesses at any byte address into word-aligned
// accesses. Accesses that cross a word boundary are split into two.
// Load data is merged and extended, then returned as one registered response.
// Ports:
//   clk, rst_n (sync, active-low)
//   req_*/addr_i/we_i/data_type_i/data_sign_ext_i/wdata_i : request in
//   mem_* : word-aligned TCM access (rdata valid one cycle after mem_req_o)
//   rsp_valid_o/rdata_o/err_o : registered one-cycle response
module lsu_misalign_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [1:0]            data_type_i,
    input  logic                  data_sign_ext_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC0 = 3'd1,
        S_ACC1 = 3'd2,
        S_CAPT = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]            r_off;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_be8;
    logic [63:0]           r_wd64;
    logic                  r_split;
    logic                  r_we;
    logic [1:0]            r_type;
    logic                  r_sext;
    logic [31:0]           r_lo;

    logic                  w_accept;
    logic [3:0]            w_base_be;
    logic [7:0]            w_be8;
    logic [63:0]           w_wd64;
    logic                  w_split;
    logic [55:0]           w_cat;
    logic [31:0]           w_r;
    logic [31:0]           w_ext;

    assign req_ready_o = (r_state == S_IDLE);
    assign w_accept    = req_valid_i && req_ready_o;

    always_comb begin
        w_base_be = 4'b1111;
        case (data_type_i)
            2'b00:   w_base_be = 4'b0001;
            2'b01:   w_base_be = 4'b0011;
            default: w_base_be = 4'b1111;
        endcase
    end

    assign w_be8   = {4'h0, w_base_be} << addr_i[1:0];
    assign w_wd64  = {32'h0, wdata_i} << {addr_i[1:0], 3'b000};
    assign w_split = ((data_type_i == 2'b01) && (addr_i[1:0] == 2'd3)) ||
                     ((data_type_i == 2'b10) && (addr_i[1:0] != 2'd0));

    // Byte 3 of the high word is never needed: the widest crossing access
    // (word at offset 3) ends at byte 6 of the merged pair.
    assign w_cat = r_split ? {mem_rdata_i[23:0], r_lo}
                           : {24'h0, mem_rdata_i};

    always_comb begin
        w_r = w_cat[31:0];
        case (r_off)
            2'd0: w_r = w_cat[31:0];
            2'd1: w_r = w_cat[39:8];
            2'd2: w_r = w_cat[47:16];
            2'd3: w_r = w_cat[55:24];
            default: w_r = w_cat[31:0];
        endcase
    end

    always_comb begin
        w_ext = w_r;
        case (r_type)
            2'b00:   w_ext = {{24{r_sext & w_r[7]}}, w_r[7:0]};
            2'b01:   w_ext = {{16{r_sext & w_r[15]}}, w_r[15:0]};
            default: w_ext = w_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_wdata_o = '0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_next = (data_type_i == 2'b11) ? S_ERR : S_ACC0;
                end
            end
            S_ACC0: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = r_waddr;
                mem_we_o    = r_we;
                mem_be_o    = r_be8[3:0];
                mem_wdata_o = r_wd64[31:0];
                w_next      = r_split ? S_ACC1 : S_CAPT;
            end
            S_ACC1: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = r_waddr + ADDR_WIDTH'(4);
                mem_we_o    = r_we;
                mem_be_o    = r_be8[7:4];
                mem_wdata_o = r_wd64[63:32];
                w_next      = S_CAPT;
            end
            S_CAPT:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_off       <= 2'd0;
            r_waddr     <= '0;
            r_be8       <= 8'h0;
            r_wd64      <= 64'h0;
            r_split     <= 1'b0;
            r_we        <= 1'b0;
            r_type      <= 2'b00;
            r_sext      <= 1'b0;
            r_lo        <= 32'h0;
            rsp_valid_o <= 1'b0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (w_accept) begin
                r_off   <= addr_i[1:0];
                r_waddr <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                r_be8   <= w_be8;
                r_wd64  <= w_wd64;
                r_split <= w_split;
                r_we    <= we_i;
                r_type  <= data_type_i;
                r_sext  <= data_sign_ext_i;
            end
            if (r_state == S_ACC1) begin
                r_lo <= mem_rdata_i;
            end
            if (r_state == S_CAPT) begin
                rsp_valid_o <= 1'b1;
                err_o       <= 1'b0;
                rdata_o     <= r_we ? '0 : w_ext;
            end
            if (r_state == S_ERR) begin
                rsp_valid_o <= 1'b1;
                err_o       <= 1'b1;
                rdata_o     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_misalign_ctrl.sv
// tb_lsu_misalign_ctrl: directed bench for lsu_misalign_ctrl.
// Word memory model answers one cycle after each access; responses checked.
module tb_lsu_misalign_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [1:0]  data_type_i;
    logic        data_sign_ext_i;
    logic [31:0] wdata_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        rsp_valid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem [256];
    logic [31:0] q_addr [$];
    logic [3:0]  q_be [$];
    logic [31:0] q_wd [$];
    logic        q_we [$];

    int          lat;
    logic [31:0] g_rdata;
    logic        g_err;

    always #5 clk = ~clk;

    lsu_misalign_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .addr_i          (addr_i),
        .we_i            (we_i),
        .data_type_i     (data_type_i),
        .data_sign_ext_i (data_sign_ext_i),
        .wdata_i         (wdata_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rdata_i     (mem_rdata_i),
        .rsp_valid_o     (rsp_valid_o),
        .rdata_o         (rdata_o),
        .err_o           (err_o)
    );

    always @(posedge clk) begin
        if (mem_req_o && !mem_we_o)
            mem_rdata_i <= mem[mem_addr_o[9:2]];
        else
            mem_rdata_i <= 32'h0;
        if (mem_req_o && mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_be_o[b])
                    mem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
    end

    always @(negedge clk) begin
        if (mem_req_o) begin
            q_addr.push_back(mem_addr_o);
            q_be.push_back(mem_be_o);
            q_wd.push_back(mem_wdata_o);
            q_we.push_back(mem_we_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic w,
                       input logic [1:0] t, input logic s,
                       input logic [31:0] wd);
        @(negedge clk);
        q_addr.delete();
        q_be.delete();
        q_wd.delete();
        q_we.delete();
        req_valid_i     = 1'b1;
        addr_i          = a;
        we_i            = w;
        data_type_i     = t;
        data_sign_ext_i = s;
        wdata_i         = wd;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        lat     = 0;
        g_rdata = 32'hxxxxxxxx;
        g_err   = 1'bx;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                lat     = n;
                g_rdata = rdata_o;
                g_err   = err_o;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n           = 1'b0;
        req_valid_i     = 1'b0;
        addr_i          = 32'h0;
        we_i            = 1'b0;
        data_type_i     = 2'b00;
        data_sign_ext_i = 1'b0;
        wdata_i         = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
        chk("rst_mreq", {31'h0, mem_req_o}, 32'h0);
        chk("rst_maddr", mem_addr_o, 32'h0);
        chk("rst_mbe", {28'h0, mem_be_o}, 32'h0);
        chk("rst_rsp", {31'h0, rsp_valid_o}, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_err", {31'h0, err_o}, 32'h0);

        // aligned LW
        mem[8'h40] = 32'hDEADBEEF;
        run(32'h100, 1'b0, 2'b10, 1'b0, 32'h0);
        chk("lw_lat", lat, 32'd3);
        chk("lw_rdata", g_rdata, 32'hDEADBEEF);
        chk("lw_err", {31'h0, g_err}, 32'h0);
        chk("lw_nacc", q_addr.size(), 32'd1);
        chk("lw_addr", q_addr[0], 32'h100);
        chk("lw_be", {28'h0, q_be[0]}, 32'hF);

        // LB / LBU at offset 3
        mem[8'h40] = 32'h80112233;
        run(32'h103, 1'b0, 2'b00, 1'b1, 32'h0);
        chk("lb_lat", lat, 32'd3);
        chk("lb_be", {28'h0, q_be[0]}, 32'h8);
        chk("lb_rdata", g_rdata, 32'hFFFFFF80);
        run(32'h103, 1'b0, 2'b00, 1'b0, 32'h0);
        chk("lbu_rdata", g_rdata, 32'h00000080);

        // misaligned LW split across 0x100/0x104
        mem[8'h40] = 32'h4433AABB;
        mem[8'h41] = 32'h88776655;
        run(32'h102, 1'b0, 2'b10, 1'b0, 32'h0);
        chk("mlw_lat", lat, 32'd4);
        chk("mlw_nacc", q_addr.size(), 32'd2);
        chk("mlw_a0", q_addr[0], 32'h100);
        chk("mlw_be0", {28'h0, q_be[0]}, 32'hC);
        chk("mlw_a1", q_addr[1], 32'h104);
        chk("mlw_be1", {28'h0, q_be[1]}, 32'h3);
        chk("mlw_rdata", g_rdata, 32'h66554433);

        // LH at offset 1 stays in one word
        run(32'h101, 1'b0, 2'b01, 1'b1, 32'h0);
        chk("lh1_lat", lat, 32'd3);
        chk("lh1_nacc", q_addr.size(), 32'd1);
        chk("lh1_be", {28'h0, q_be[0]}, 32'h6);
        chk("lh1_rdata", g_rdata, 32'h000033AA);

        // SH at offset 3 splits
        run(32'h203, 1'b1, 2'b01, 1'b0, 32'h0000CAFE);
        chk("sh_lat", lat, 32'd4);
        chk("sh_nacc", q_addr.size(), 32'd2);
        chk("sh_a0", q_addr[0], 32'h200);
        chk("sh_be0", {28'h0, q_be[0]}, 32'h8);
        chk("sh_wd0", q_wd[0], 32'hFE000000);
        chk("sh_we0", {31'h0, q_we[0]}, 32'h1);
        chk("sh_a1", q_addr[1], 32'h204);
        chk("sh_be1", {28'h0, q_be[1]}, 32'h1);
        chk("sh_wd1", q_wd[1], 32'h000000CA);
        chk("sh_rdata", g_rdata, 32'h0);

        // address wrap on the second access
        mem[8'hFF] = 32'h11223344;
        mem[8'h00] = 32'h55667788;
        run(32'hFFFFFFFE, 1'b0, 2'b10, 1'b0, 32'h0);
        chk("wrap_nacc", q_addr.size(), 32'd2);
        chk("wrap_a0", q_addr[0], 32'hFFFFFFFC);
        chk("wrap_a1", q_addr[1], 32'h00000000);
        chk("wrap_rdata", g_rdata, 32'h77881122);

        // illegal data type
        run(32'h100, 1'b0, 2'b11, 1'b0, 32'h0);
        chk("ill_lat", lat, 32'd2);
        chk("ill_err", {31'h0, g_err}, 32'h1);
        chk("ill_nacc", q_addr.size(), 32'd0);
        chk("ill_rdata", g_rdata, 32'h0);

        // reset during ACC1 of a split store
        @(negedge clk);
        req_valid_i     = 1'b1;
        addr_i          = 32'h301;
        we_i            = 1'b1;
        data_type_i     = 2'b10;
        data_sign_ext_i = 1'b0;
        wdata_i         = 32'h12345678;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("rs_acc0_req", {31'h0, mem_req_o}, 32'h1);
        chk("rs_acc0_addr", mem_addr_o, 32'h300);
        chk("rs_acc0_be", {28'h0, mem_be_o}, 32'hE);
        chk("rs_acc0_wd", mem_wdata_o, 32'h34567800);
        @(negedge clk);
        chk("rs_acc1_addr", mem_addr_o, 32'h304);
        chk("rs_acc1_be", {28'h0, mem_be_o}, 32'h1);
        chk("rs_acc1_wd", mem_wdata_o, 32'h00000012);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rs_mreq", {31'h0, mem_req_o}, 32'h0);
        chk("rs_rsp", {31'h0, rsp_valid_o}, 32'h0);
        chk("rs_ready", {31'h0, req_ready_o}, 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_rsp2", {31'h0, rsp_valid_o}, 32'h0);
        mem[8'h40] = 32'hDEADBEEF;
        run(32'h100, 1'b0, 2'b10, 1'b0, 32'h0);
        chk("post_lat", lat, 32'd3);
        chk("post_rdata", g_rdata, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
